// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM encoding and GF(2^8)/key-schedule helpers
//
// Purpose: common definitions for the iterative AES-128 decryptor.
//   AES_NR            number of AES-128 rounds
//   state_e           decryptor FSM encoding
//   rcon()            round constant for round 1..10 (0 elsewhere)
//   xtime()/gmul()    GF(2^8) arithmetic, modulus x^8+x^4+x^3+x+1
//   sbox()/inv_sbox() forward/inverse S-box computed from the field inverse
//   fwd_expand()      next round key from the current one
//   inv_expand()      previous round key from the current one
// No ports (package).

package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KEXP  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine transform (rotates by 1, 3, 6 plus 0x05), then field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = rk[31:0]  ^ rk[63:32];
        n2 = rk[63:32] ^ rk[95:64];
        n1 = rk[95:64] ^ rk[127:96];
        n0 = rk[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
//
// Purpose: st_next = InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ prk),
//          with InvMixColumns bypassed when last_flag is set.
// Ports:
//   st        in  128  current state, byte 0 in [127:120], column-major
//   prk       in  128  round key applied in this round
//   last_flag in  1    final round (no InvMixColumns)
//   st_next   out 128  state after the round

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] prk,
    input  logic         last_flag,
    output logic [127:0] st_next
);

    logic [7:0] sb [16];
    logic [7:0] ak [16];

    always_comb begin
        // Byte index is 4*col+row; row r is rotated right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[4*c+r] = inv_sbox(st[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ak[i] = sb[i] ^ prk[127-8*i -: 8];
        end
        st_next = '0;
        for (int c = 0; c < 4; c++) begin
            if (last_flag) begin
                for (int r = 0; r < 4; r++) begin
                    st_next[127-8*(4*c+r) -: 8] = ak[4*c+r];
                end
            end else begin
                st_next[127-32*c -: 8] = gmul(ak[4*c], 8'h0e) ^ gmul(ak[4*c+1], 8'h0b)
                                       ^ gmul(ak[4*c+2], 8'h0d) ^ gmul(ak[4*c+3], 8'h09);
                st_next[119-32*c -: 8] = gmul(ak[4*c], 8'h09) ^ gmul(ak[4*c+1], 8'h0e)
                                       ^ gmul(ak[4*c+2], 8'h0b) ^ gmul(ak[4*c+3], 8'h0d);
                st_next[111-32*c -: 8] = gmul(ak[4*c], 8'h0d) ^ gmul(ak[4*c+1], 8'h09)
                                       ^ gmul(ak[4*c+2], 8'h0e) ^ gmul(ak[4*c+3], 8'h0b);
                st_next[103-32*c -: 8] = gmul(ak[4*c], 8'h0b) ^ gmul(ak[4*c+1], 8'h0d)
                                       ^ gmul(ak[4*c+2], 8'h09) ^ gmul(ak[4*c+3], 8'h0e);
            end
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decryptor, one round per clock
//
// Purpose: accepts ciphertext + key, expands the key forward to round key 10
//          (10 cycles), then runs 10 inverse rounds while walking the key
//          schedule backwards (10 cycles), and presents the plaintext.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset
//   in_valid  in  1      data_in/key valid
//   in_ready  out 1      idle, block can be accepted
//   data_in   in  KEY_W  ciphertext, byte 0 in [127:120]
//   key       in  KEY_W  cipher key, same byte order
//   out_valid out 1      data_out holds a completed plaintext
//   out_ready in  1      downstream accepts data_out
//   data_out  out KEY_W  recovered plaintext

module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] data_in,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] data_out
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] data_out_q, data_out_d;
    logic         out_valid_q, out_valid_d;

    logic [127:0] prk;
    logic [127:0] round_st;

    // Previous round key; consumed only in ROUND, where rnd_q is 10..1.
    assign prk = inv_expand(rk_q, rcon(rnd_q));

    aes_inv_round u_round (
        .st        (st_q),
        .prk       (prk),
        .last_flag (rnd_q == 4'd1),
        .st_next   (round_st)
    );

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = data_in;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    state_d = S_KEXP;
                end
            end
            S_KEXP: begin
                rk_d = fwd_expand(rk_q, rcon(rnd_q));
                if (rnd_q == LAST_RND) begin
                    // rk_d is round key 10 here: initial AddRoundKey.
                    st_d    = st_q ^ rk_d;
                    state_d = S_ROUND;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_ROUND: begin
                rk_d = prk;
                st_d = round_st;
                if (rnd_q == 4'd1) begin
                    data_out_d  = round_st;
                    out_valid_d = 1'b1;
                    rnd_d       = 4'd0;
                    state_d     = S_DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule
